// File: rtl/proc_pkg.sv
// Shared types and constants for the processor fetch path.
package proc_pkg;
  localparam int INSTR_WIDTH = 32;
  localparam int PC_STEP     = 4;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    VALID = 2'd1,
    FAULT = 2'd2
  } fetch_state_t;

  function automatic logic is_word_aligned(input logic [1:0] low_bits);
    return (low_bits == 2'b00);
  endfunction
endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch-to-consumer handshake: instruction/PC out, retire and redirect back.
interface instr_fetch_unit_if #(
  parameter int PC_WIDTH = 32
);
  logic [31:0]         instr;
  logic [PC_WIDTH-1:0] pc_out;
  logic [PC_WIDTH-1:0] pc_plus4;
  logic                instr_valid;
  logic                instr_ready;
  logic                redirect;
  logic [PC_WIDTH-1:0] redirect_target;

  modport master (
    output instr, pc_out, pc_plus4, instr_valid,
    input  instr_ready, redirect, redirect_target
  );

  modport slave (
    input  instr, pc_out, pc_plus4, instr_valid,
    output instr_ready, redirect, redirect_target
  );
endinterface

// File: rtl/instr_fetch_unit_pc_reg.sv
// Program counter: reset/increment/redirect select with a registered pc+4.
module pc_reg
  import proc_pkg::*;
#(
  parameter int                  PC_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC = {PC_WIDTH{1'b0}}
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                inc_en,
  input  logic                redirect_en,
  input  logic [PC_WIDTH-1:0] redirect_target,
  output logic [PC_WIDTH-1:0] pc,
  output logic [PC_WIDTH-1:0] pc_plus4
);
  localparam logic [PC_WIDTH-1:0] STEP = PC_WIDTH'(PC_STEP);

  logic [PC_WIDTH-1:0] pc_r;
  logic [PC_WIDTH-1:0] pc_plus4_r;
  logic [PC_WIDTH-1:0] pc_next_s;

  // Next-PC select; redirect wins over sequential increment.
  always_comb begin
    pc_next_s = pc_r;
    if (redirect_en) begin
      pc_next_s = redirect_target;
    end else if (inc_en) begin
      pc_next_s = pc_plus4_r;
    end else begin
      pc_next_s = pc_r;
    end
  end

  // PC and pc+4 registers; pc+4 wraps modulo 2^PC_WIDTH.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_r       <= RESET_PC;
      pc_plus4_r <= RESET_PC + STEP;
    end else begin
      pc_r       <= pc_next_s;
      pc_plus4_r <= pc_next_s + STEP;
    end
  end

  assign pc       = pc_r;
  assign pc_plus4 = pc_plus4_r;
endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC, instruction register and FETCH/VALID/FAULT control.
// Optional macro FETCH_RANGE_CHECK_EN faults on next-PCs beyond instruction memory.
module instr_fetch_unit
  import proc_pkg::*;
#(
  parameter int                  PC_WIDTH = 32,
  parameter int                  IMEM_AW  = 6,
  parameter logic [PC_WIDTH-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               reset_n,
  output logic [IMEM_AW-1:0] imem_addr,
  input  word_t              imem_rdata,
  output logic               fault,
  instr_fetch_unit_if.master fetch
);
  localparam logic [1:0] ST_FETCH = FETCH;
  localparam logic [1:0] ST_VALID = VALID;
  localparam logic [1:0] ST_FAULT = FAULT;

  logic [1:0]          state_r;
  logic [1:0]          state_next_s;
  word_t               instr_r;
  logic                instr_valid_r;
  logic                fault_r;
  logic [PC_WIDTH-1:0] pc_s;
  logic [PC_WIDTH-1:0] pc_plus4_s;
  logic                retire_s;
  logic                misalign_s;
  logic                range_err_s;
  logic                bad_next_s;
  logic                pc_inc_s;
  logic                pc_redir_s;

  assign retire_s   = (state_r == ST_VALID) & instr_valid_r & fetch.instr_ready;
  assign misalign_s = fetch.redirect & ~is_word_aligned(fetch.redirect_target[1:0]);

`ifdef FETCH_RANGE_CHECK_EN
  logic [PC_WIDTH-1:0] next_pc_s;
  assign next_pc_s   = fetch.redirect ? fetch.redirect_target : pc_plus4_s;
  assign range_err_s = |next_pc_s[PC_WIDTH-1:IMEM_AW+2];
`else
  assign range_err_s = 1'b0;
`endif

  assign bad_next_s = misalign_s | range_err_s;
  assign pc_inc_s   = retire_s & ~fetch.redirect & ~bad_next_s;
  assign pc_redir_s = retire_s &  fetch.redirect & ~bad_next_s;

  pc_reg #(
    .PC_WIDTH (PC_WIDTH),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk             (clk),
    .reset_n         (reset_n),
    .inc_en          (pc_inc_s),
    .redirect_en     (pc_redir_s),
    .redirect_target (fetch.redirect_target),
    .pc              (pc_s),
    .pc_plus4        (pc_plus4_s)
  );

  // Fetch control; a bad next-PC parks the unit in FAULT until reset.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_FETCH: state_next_s = ST_VALID;
      ST_VALID: begin
        if (retire_s) begin
          state_next_s = bad_next_s ? ST_FAULT : ST_FETCH;
        end else begin
          state_next_s = ST_VALID;
        end
      end
      ST_FAULT: state_next_s = ST_FAULT;
      default:  state_next_s = ST_FAULT;
    endcase
  end

  // State, instruction register and registered status outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r       <= ST_FETCH;
      instr_r       <= 32'h0000_0000;
      instr_valid_r <= 1'b0;
      fault_r       <= 1'b0;
    end else begin
      state_r       <= state_next_s;
      instr_valid_r <= (state_next_s == ST_VALID);
      fault_r       <= (state_next_s == ST_FAULT);
      if (state_r == ST_FETCH) begin
        instr_r <= imem_rdata;
      end
    end
  end

  assign imem_addr         = pc_s[IMEM_AW+1:2];
  assign fetch.instr       = instr_r;
  assign fetch.pc_out      = pc_s;
  assign fetch.pc_plus4    = pc_plus4_s;
  assign fetch.instr_valid = instr_valid_r;
  assign fault             = fault_r;
endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Fetch stage for the 32-bit non-pipelined processor; sits directly upstream of the instruction memory and feeds it a 6-bit word address.
- Owns the program counter. Latches the returned 32-bit word into an instruction register and presents it to decode/execute over a valid/ready handshake.
- Accepts a branch/jump redirect on instruction retirement; detects misaligned targets.

Parameters:
- PC_WIDTH, 32, program counter width in bits
- IMEM_AW, 6, instruction memory word-address width
- RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word-aligned

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- imem_addr  out  IMEM_AW  word address to instruction memory, = pc[IMEM_AW+1:2]
- imem_rdata  in  32  combinational read data from instruction memory
- instr  out  32  instruction register contents
- pc_out  out  PC_WIDTH  byte address of the instruction held in instr
- pc_plus4  out  PC_WIDTH  pc_out + 4, for link/branch arithmetic
- instr_valid  out  1  instr/pc_out valid for consumer
- instr_ready  in  1  consumer retires the current instruction
- redirect  in  1  taken branch/jump; sampled only on retire
- redirect_target  in  PC_WIDTH  next PC when redirect=1
- fault  out  1  sticky fetch fault

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on reset_n.
- Reset values: pc=RESET_PC, instr=32'h0, state=FETCH, instr_valid=0, fault=0.
- Reset mid-operation aborts any fetch or pending instruction immediately. The first fetch after release is at RESET_PC.
- FSM states: FETCH, VALID, FAULT.
- FETCH:
  - imem_addr is driven from pc; memory is combinational.
  - On the next rising edge: instr<=imem_rdata and state->VALID.
  - Fetch latency is 1 cycle from entering FETCH to instr_valid=1.
- VALID:
  - instr_valid=1. instr and pc_out are held stable while instr_ready=0, for any number of cycles.
  - Retire condition: instr_valid & instr_ready at a rising edge.
  - On retire with redirect=0: pc<=pc+4, state->FETCH.
  - On retire with redirect=1 and redirect_target[1:0]==0: pc<=redirect_target, state->FETCH.
  - On retire with redirect=1 and redirect_target[1:0]!=0: state->FAULT, pc unchanged.
  - redirect and redirect_target are ignored when no retire occurs.
- FAULT: fault=1, instr_valid=0. The state is held until reset; imem_addr stays at the last pc.
- Throughput: one instruction per 2 cycles when instr_ready is held at 1.
- Arithmetic: pc+4 is modulo 2^PC_WIDTH (0xFFFF_FFFC+4 -> 0).
- imem_addr takes bits [IMEM_AW+1:2], so PC values beyond 4*2^IMEM_AW alias (pc 0x100 -> imem_addr 0) unless the optional feature is enabled.
- instr_ready asserted while instr_valid=0 has no effect.

Optional Feature:
- Macro: FETCH_RANGE_CHECK_EN
- Defined: any next-pc (increment or redirect) with pc[PC_WIDTH-1:IMEM_AW+2]!=0 sends the FSM to FAULT instead of FETCH; fault=1.
  - Example: the retire at pc 0xFC with no redirect -> FAULT.
- Undefined: no range check; addresses alias modulo memory size; fault is raised only by misalignment.

Decomposition:
- Shared package proc_pkg:
  - typedef fetch_state_t enum {FETCH, VALID, FAULT}
  - constant INSTR_WIDTH=32
  - constant PC_STEP=4
  - typedef word_t logic[31:0]
- One natural sub-module, pc_reg: holds the PC, selects reset/increment/redirect, computes pc_plus4.
- FSM and instruction register remain in the top.

Test Plan:
- Reset sequence: reset_n=0, memory word0=32'h2002_0005 -> after release, imem_addr=0 and the next cycle gives instr_valid=1, instr=32'h2002_0005, pc_out=0, pc_plus4=4.
- Sequential stream: instr_ready=1 continuously, redirect=0, words 0..3 preloaded -> pc_out sequence 0,4,8,C; instr_valid pulses every 2nd cycle; instr matches word n.
- Backpressure: hold instr_ready=0 for 5 cycles in VALID -> instr/pc_out unchanged, imem_addr unchanged, no pc advance; releasing instr_ready gives exactly one retire.
- Redirect: retire at pc=8 with redirect=1, target=32'h0000_0020 -> next imem_addr=6'h08, pc_out=0x20. redirect=1 without instr_ready is ignored.
- Misaligned target and reset: retire with target=32'h0000_0022 -> fault=1, instr_valid=0, held indefinitely. reset_n low clears fault, and fetch restarts at RESET_PC.
- Wrap/range: retire at pc=0xFC with redirect=0:
  - Without FETCH_RANGE_CHECK_EN -> imem_addr=0, pc_out=0x100.
  - With FETCH_RANGE_CHECK_EN -> fault=1.
